uart_tx_fifo: RTL and testbench
===============================

Name: uart_tx_fifo

Overview:
- Synthesizable 8N1 UART transmitter with a byte FIFO on the front.
- Sits in the DUT directly upstream of the testbench serial model. Its txd pin drives the model's RX.
- Sequencer logic pushes ASCII bytes through a valid/ready interface. The block serialises them LSB-first, back-to-back, at the configured baud.

Parameters:
- CLK_FREQ, 100000000, system clock frequency in Hz.
- BAUD, 115200, line rate. Bit period DIV = CLK_FREQ/BAUD, integer division. DIV must be at least 2.
- FIFO_DEPTH, 16, byte entries. Must be a power of two, at least 2.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- tx_data  input  8  byte to enqueue.
- tx_valid  input  1  tx_data is valid this cycle.
- tx_ready  output  1  FIFO can accept a byte. Equals !full.
- txd  output  1  serial line. Idles high. Registered output.
- busy  output  1  high when the FSM is not IDLE or the FIFO is not empty.
- fifo_count  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (rst_n low, asynchronous):
  - txd=1, tx_ready=1, busy=0, fifo_count=0.
  - FSM goes to IDLE; bit counter and shift register cleared.
  - Reset mid-frame aborts the frame immediately: txd goes high with no glitch low and FIFO contents are discarded.
- Push: a byte is written when tx_valid && tx_ready on a rising edge. If tx_valid is high while full, nothing is written and nothing is lost internally; the source holds the byte.
- FIFO: write and read pointers wrap at FIFO_DEPTH.
  - Push and pop on the same edge: fifo_count unchanged, both pointers advance.
  - Full: push is blocked via tx_ready=0. A pop on that edge sets tx_ready=1 on the next cycle, not combinationally.
- Bit timer: counts DIV-1 down to 0. Every line state, including start and stop bits, holds for exactly DIV clocks.
- FSM states:
  - IDLE: txd=1. If the FIFO is non-empty, pop the head into the shift register, drive txd<=0 and go to START.
  - START: after DIV cycles, txd<=shift[0] and go to DATA with bit index 0.
  - DATA: after each DIV cycles, shift right and increment the index. After the 8th bit's period, txd<=1 and go to STOP.
  - STOP: after DIV cycles, if the FIFO is non-empty, pop, drive txd<=0 and go to START (no idle gap). Otherwise go to IDLE.
- Latency: for a byte accepted at edge E into an empty FIFO with the FSM in IDLE, txd falls at edge E+1.
- Frame length: 10*DIV clocks. Back-to-back frames are contiguous.
- Ordering: strict FIFO order, LSB first. No parity.

Optional Feature:
- Macro: UART_TX_CRLF_EN.
- Enabled:
  - Popping 0x0A makes the FSM first transmit a full 0x0D frame, then the 0x0A frame, with no second pop. A pending-LF flag holds the 0x0A.
  - busy stays high across both frames.
  - Reset clears the pending-LF flag.
  - 0x0D written explicitly is sent as-is, so a 0D,0A input is sent as 0D,0D,0A.
- Disabled: every byte is sent unchanged and there is no pending-LF state.

Test Plan:
All scenarios use CLK_FREQ=1843200 and BAUD=115200, so DIV=16.
1. Single byte: push 0x41 from idle.
   - txd falls one clock after the accept edge.
   - Low for 16 clocks, then bits 1,0,0,0,0,0,1,0 at 16 clocks each, then high.
   - busy drops 160 clocks after txd falls.
   - The serial model decodes 0x41.
2. Back-to-back: push "AB\n" in three consecutive cycles.
   - Three contiguous frames, 480 clocks, no idle between stop and next start.
   - Model prints instruction 00004142.
3. Full FIFO: push 17 bytes continuously with tx_valid held.
   - fifo_count reaches 16 (first byte popped at E+1, so the 17th is accepted after the first pop).
   - tx_ready low while full.
   - All 17 bytes transmitted in order, none dropped.
4. Simultaneous push/pop: push a byte on the exact edge the FSM pops (STOP to START).
   - fifo_count unchanged that edge; data order preserved.
5. Reset mid-frame: assert rst_n low 50 clocks into the data bits of 0x55.
   - txd=1 asynchronously; fifo_count=0, busy=0.
   - After release, push 0x31: clean frame, model decodes 0x31.
6. With UART_TX_CRLF_EN: push 0x0A. Line carries 0x0D then 0x0A, 320 clocks, single pop. Without the macro: only 0x0A, 160 clocks.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter fed by a power-of-two byte FIFO over a valid/ready port.
// Optional build macro UART_TX_CRLF_EN: each popped LF is sent as a CR frame then an LF frame.
module uart_tx_fifo #(
   parameter int unsigned CLK_FREQ   = 100000000,
   parameter int unsigned BAUD       = 115200,
   parameter int unsigned FIFO_DEPTH = 16
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [7:0]                  tx_data,
   input  logic                        tx_valid,
   output logic                        tx_ready,
   output logic                        txd,
   output logic                        busy,
   output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

   localparam int unsigned DIV = CLK_FREQ / BAUD;
   localparam int unsigned TW  = $clog2(DIV);
   localparam int unsigned AW  = $clog2(FIFO_DEPTH);
   localparam int unsigned CW  = AW + 1;
   localparam logic [TW-1:0] TMR_MAX = TW'(DIV - 1);

   typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

   logic [7:0]    mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] count;
   logic          push, pop, empty, full;
   logic [7:0]    head, load_byte;
   logic          expand_lf, lf_q, tick;

   state_e        state_q, state_d;
   logic [TW-1:0] tmr_q, tmr_d;
   logic [2:0]    idx_q, idx_d;
   logic [7:0]    shift_q, shift_d;
   logic          txd_q, txd_d;

   assign empty      = count == '0;
   assign full       = count == CW'(FIFO_DEPTH);
   assign tx_ready   = !full;
   assign push       = tx_valid && !full;
   assign head       = mem[rd_ptr];
   assign fifo_count = count;
   assign txd        = txd_q;
   assign tick       = tmr_q == '0;
   assign load_byte  = expand_lf ? 8'h0D : head;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         count <= count + CW'(push) - CW'(pop);
      end
   end

   // Storage needs no reset: pointer reset alone discards the contents.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= tx_data;
   end

`ifdef UART_TX_CRLF_EN
   logic lf_d;

   assign expand_lf = head == 8'h0A;

   // Holds the LF that still has to follow the CR frame substituted for it.
   always_comb begin
      lf_d = lf_q;
      if (pop) begin
         lf_d = expand_lf;
      end else if (state_q == StStop && tick) begin
         lf_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) lf_q <= 1'b0;
      else        lf_q <= lf_d;
   end
`else
   assign expand_lf = 1'b0;
   assign lf_q      = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         tmr_q   <= '0;
         idx_q   <= '0;
         shift_q <= '0;
         txd_q   <= 1'b1;
      end else begin
         state_q <= state_d;
         tmr_q   <= tmr_d;
         idx_q   <= idx_d;
         shift_q <= shift_d;
         txd_q   <= txd_d;
      end
   end

   always_comb begin
      state_d = state_q;
      tmr_d   = tmr_q;
      idx_d   = idx_q;
      shift_d = shift_q;
      txd_d   = txd_q;
      case (state_q)
         StIdle: begin
            if (!empty) begin
               state_d = StStart;
               tmr_d   = TMR_MAX;
               shift_d = load_byte;
               txd_d   = 1'b0;
            end
         end
         StStart: begin
            if (tick) begin
               state_d = StData;
               tmr_d   = TMR_MAX;
               idx_d   = '0;
               txd_d   = shift_q[0];
            end else begin
               tmr_d = tmr_q - TW'(1);
            end
         end
         StData: begin
            if (tick) begin
               tmr_d = TMR_MAX;
               if (idx_q == 3'd7) begin
                  state_d = StStop;
                  txd_d   = 1'b1;
               end else begin
                  shift_d = {1'b0, shift_q[7:1]};
                  txd_d   = shift_q[1];
                  idx_d   = idx_q + 3'd1;
               end
            end else begin
               tmr_d = tmr_q - TW'(1);
            end
         end
         StStop: begin
            if (tick) begin
               if (lf_q || !empty) begin
                  state_d = StStart;
                  tmr_d   = TMR_MAX;
                  shift_d = lf_q ? 8'h0A : load_byte;
                  txd_d   = 1'b0;
               end else begin
                  state_d = StIdle;
               end
            end else begin
               tmr_d = tmr_q - TW'(1);
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      pop  = !empty && ((state_q == StIdle) || (state_q == StStop && tick && !lf_q));
      busy = (state_q != StIdle) || !empty;
   end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo at DIV=16; a negedge serial model checks every frame bit by bit.
module tb_uart_tx_fifo;

   localparam int unsigned DEPTH = 16;
`ifdef UART_TX_CRLF_EN
   localparam bit CRLF = 1'b1;
`else
   localparam bit CRLF = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] tx_data = 8'h00;
   logic       tx_valid = 1'b0;
   logic       tx_ready, txd, busy;
   logic [4:0] fifo_count;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;
   int unsigned cyc = 0;
   logic [7:0]  sb[$];
   int unsigned start_cyc[$];
   int unsigned max_cnt = 0;
   bit          ready_err = 1'b0;

   uart_tx_fifo #(
      .CLK_FREQ  (1843200),
      .BAUD      (115200),
      .FIFO_DEPTH(DEPTH)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .tx_data   (tx_data),
      .tx_valid  (tx_valid),
      .tx_ready  (tx_ready),
      .txd       (txd),
      .busy      (busy),
      .fifo_count(fifo_count)
   );

   always #5 clk = ~clk;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no finish, expected finish before 1ms");
      $fatal(1, "watchdog expired");
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic sb_push(input logic [7:0] b);
      if (CRLF && b == 8'h0A) sb.push_back(8'h0D);
      sb.push_back(b);
   endtask

   // Serial model: samples each negedge, compares every cycle of the frame against the
   // expected 10-bit pattern and decodes the byte at mid-bit.
   initial begin : rx_model
      bit          active = 1'b0;
      int unsigned cnt = 0;
      logic [9:0]  frame = '1;
      logic [7:0]  exp_b = 8'h00;
      logic [7:0]  got_b = 8'h00;
      bit          shape_ok = 1'b1;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (fifo_count > max_cnt) max_cnt = fifo_count;
            if (tx_ready !== (fifo_count != DEPTH)) ready_err = 1'b1;
         end
         if (!rst_n) begin
            active = 1'b0;
         end else if (!active && txd === 1'b0) begin
            active = 1'b1;
            cnt = 0;
            shape_ok = 1'b1;
            start_cyc.push_back(cyc);
            if (sb.size() == 0) begin
               check_eq("unexpected_frame", 32'd1, 32'd0);
               exp_b = 8'h00;
            end else begin
               exp_b = sb[0];
            end
            frame = {1'b1, exp_b, 1'b0};
         end
         if (active && rst_n) begin
            if (txd !== frame[cnt / 16]) shape_ok = 1'b0;
            if (cnt % 16 == 8 && cnt / 16 >= 1 && cnt / 16 <= 8) got_b[cnt / 16 - 1] = txd;
            if (cnt == 159) begin
               check_eq("frame_shape", 32'(shape_ok), 32'd1);
               check_eq("rx_byte", 32'(got_b), 32'(exp_b));
               if (sb.size() > 0) void'(sb.pop_front());
               active = 1'b0;
            end
            cnt++;
         end
      end
   end

   // Drives one byte; returns just after the edge that accepts it, tx_valid still high.
   task automatic push_byte(input logic [7:0] b);
      int unsigned w = 0;
      @(negedge clk);
      tx_data  = b;
      tx_valid = 1'b1;
      while (!tx_ready && w < 400) begin
         @(negedge clk);
         w++;
      end
      if (!tx_ready) check_eq("push_timeout", 32'(tx_ready), 32'd1);
      else sb_push(b);
      @(posedge clk);
   endtask

   task automatic release_valid();
      @(negedge clk);
      tx_valid = 1'b0;
   endtask

   task automatic wait_idle(output int unsigned at);
      int unsigned w = 0;
      @(negedge clk);
      while (busy && w < 5000) begin
         @(negedge clk);
         w++;
      end
      if (busy) check_eq("idle_timeout", 32'(busy), 32'd0);
      at = cyc;
   endtask

   task automatic check_duration(input string tag, input int unsigned mark,
                                 input int unsigned exp);
      int unsigned at;
      wait_idle(at);
      if (start_cyc.size() > mark) check_eq(tag, at - start_cyc[mark], exp);
      else check_eq({tag, "_no_frame"}, 32'(start_cyc.size()), mark + 1);
      check_eq({tag, "_drain"}, 32'(sb.size()), 32'd0);
   endtask

   initial begin
      int unsigned mark;
      @(negedge clk);
      check_eq("rst_txd", 32'(txd), 32'd1);
      check_eq("rst_ready", 32'(tx_ready), 32'd1);
      check_eq("rst_busy", 32'(busy), 32'd0);
      check_eq("rst_count", 32'(fifo_count), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      check_eq("idle_txd", 32'(txd), 32'd1);

      // Single byte latency and frame length
      mark = start_cyc.size();
      push_byte(8'h41);
      @(negedge clk);
      tx_valid = 1'b0;
      check_eq("lat_e", 32'(txd), 32'd1);
      @(negedge clk);
      check_eq("lat_e1", 32'(txd), 32'd0);
      check_duration("single_len", mark, 160);

      // Back-to-back "AB\n"
      mark = start_cyc.size();
      push_byte(8'h41);
      push_byte(8'h42);
      push_byte(8'h0A);
      release_valid();
      check_duration("b2b_len", mark, CRLF ? 640 : 480);

      // Continuous push past full depth
      max_cnt = 0;
      ready_err = 1'b0;
      mark = start_cyc.size();
      for (int i = 0; i < 20; i++) push_byte(8'h60 + 8'(i));
      release_valid();
      check_duration("full_len", mark, 20 * 160);
      check_eq("full_max_count", max_cnt, DEPTH);
      check_eq("full_ready_flag", 32'(ready_err), 32'd0);

      // Push on the same edge the STOP state pops the next byte
      mark = start_cyc.size();
      push_byte(8'hA5);
      push_byte(8'h3C);
      release_valid();
      repeat (159) @(negedge clk);
      check_eq("pp_pre_count", 32'(fifo_count), 32'd1);
      check_eq("pp_pre_txd", 32'(txd), 32'd1);
      tx_data  = 8'hC3;
      tx_valid = 1'b1;
      sb_push(8'hC3);
      @(negedge clk);
      tx_valid = 1'b0;
      check_eq("pp_count", 32'(fifo_count), 32'd1);
      check_eq("pp_start", 32'(txd), 32'd0);
      check_duration("pp_len", mark, 480);

      // Reset in the middle of data bits with a byte still queued
      push_byte(8'h55);
      push_byte(8'h77);
      release_valid();
      repeat (65) @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check_eq("mid_rst_txd", 32'(txd), 32'd1);
      check_eq("mid_rst_count", 32'(fifo_count), 32'd0);
      check_eq("mid_rst_busy", 32'(busy), 32'd0);
      sb.delete();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check_eq("rst_hold_txd", 32'(txd), 32'd1);
      end
      rst_n = 1'b1;
      @(negedge clk);
      check_eq("post_rst_count", 32'(fifo_count), 32'd0);
      check_eq("post_rst_ready", 32'(tx_ready), 32'd1);
      mark = start_cyc.size();
      push_byte(8'h31);
      release_valid();
      check_duration("post_rst_len", mark, 160);

      // LF handling: the byte behind the LF must not be popped during a CR,LF pair
      mark = start_cyc.size();
      push_byte(8'h0A);
      push_byte(8'h42);
      release_valid();
      repeat (198) @(negedge clk);
      check_eq("lf_count", 32'(fifo_count), CRLF ? 32'd1 : 32'd0);
      check_duration("lf_len", mark, CRLF ? 480 : 320);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_errors);
      $finish;
   end

endmodule
